// File: rtl/apb_isolator_qgate_pkg.sv
// apb_iso_pkg: shared types and helpers for the APB Q-channel isolation gate.
//   qstate_e      Q-channel FSM state encoding
//   APB_PPROT_W   width of the APB PPROT field
//   gate_is_open  decides whether the bus may pass through for a given state
package apb_iso_pkg;

    localparam int APB_PPROT_W = 3;

    typedef enum logic [2:0] {
        Q_RUN      = 3'd0,
        Q_REQUEST  = 3'd1,
        Q_STOPPED  = 3'd2,
        Q_EXIT     = 3'd3,
        Q_DENIED   = 3'd4,
        Q_CONTINUE = 3'd5
    } qstate_e;

    // While a quiescence request is pending, the gate stays open only long
    // enough for an already-forwarded transfer to drain.
    function automatic logic gate_is_open(input qstate_e st, input logic inflight);
        logic open;
        open = 1'b0;
        case (st)
            Q_RUN, Q_DENIED, Q_CONTINUE: open = 1'b1;
            Q_REQUEST:                   open = inflight;
            default:                     open = 1'b0;
        endcase
        return open;
    endfunction

endpackage

// File: rtl/apb_isolator_qgate_if.sv
// apb_isolator_qgate_if: one APB4 link (request + response).
//   Parameters: AW address width, DW data width (strobe width DW/8).
//   modport master: drives paddr/pprot/psel/penable/pwrite/pwdata/pstrb,
//                   receives pready/prdata/pslverr.
//   modport slave : the mirror image.
interface apb_isolator_qgate_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    import apb_iso_pkg::*;

    logic [AW-1:0]          paddr;
    logic [APB_PPROT_W-1:0] pprot;
    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [DW-1:0]          pwdata;
    logic [DW/8-1:0]        pstrb;
    logic                   pready;
    logic [DW-1:0]          prdata;
    logic                   pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_isolator_qgate_qfsm.sv
// apb_iso_qfsm: AMBA LPI Q-channel state machine for the APB isolation gate.
//   pclk_i     clock
//   preset_i   synchronous reset, active-high
//   qreqn      quiescence request (active-low)
//   inflight   a forwarded transfer has not completed downstream yet
//   blocked    an upstream transfer is waiting at a closed gate
//   state      current Q state (drives the gate decision in the top)
//   qacceptn   registered Q-channel accept (active-low)
//   qdeny      registered Q-channel deny
// Optional: define APB_ISO_TIMEOUT_EN to deny a request whose drain takes
// TO_CYCLES request cycles; otherwise the request waits for the drain.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// Q_RUN      | normal operation, gate open
// Q_REQUEST  | quiescence requested, draining any in-flight transfer
// Q_STOPPED  | accepted, gate closed, downstream may be powered off
// Q_EXIT     | request withdrawn, qacceptn still low for one cycle
// Q_DENIED   | request refused, gate open, waiting for qreqn to rise
// Q_CONTINUE | qreqn has risen after a deny, qdeny drops on the way to RUN
module apb_iso_qfsm
    import apb_iso_pkg::*;
#(
    parameter int DENY_ON_ACTIVE = 1,
    parameter int TO_CYCLES      = 64
) (
    input  logic    pclk_i,
    input  logic    preset_i,
    input  logic    qreqn,
    input  logic    inflight,
    input  logic    blocked,
    output qstate_e state,
    output logic    qacceptn,
    output logic    qdeny
);

    if (TO_CYCLES < 1) begin : g_to_check
        $error("apb_iso_qfsm: TO_CYCLES must be at least 1");
    end

    logic deny_cond;
    logic timeout;

    assign deny_cond = (DENY_ON_ACTIVE != 0) && blocked;

`ifdef APB_ISO_TIMEOUT_EN
    localparam int              CW      = $clog2(TO_CYCLES + 1);
    localparam logic [CW-1:0]   TO_LAST = CW'(TO_CYCLES - 1);

    logic [CW-1:0] to_cnt_q;

    // Fires on the TO_CYCLES-th request cycle that still has a transfer pending.
    assign timeout = inflight && (to_cnt_q == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state    <= Q_RUN;
            qacceptn <= 1'b1;
            qdeny    <= 1'b0;
`ifdef APB_ISO_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            case (state)
                Q_RUN: begin
                    if (!qreqn) begin
                        state <= Q_REQUEST;
`ifdef APB_ISO_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                    end
                end
                Q_REQUEST: begin
                    // Deny has priority: a timed-out drain or a blocked
                    // upstream transfer must not be accepted.
                    if (timeout || deny_cond) begin
                        state <= Q_DENIED;
                        qdeny <= 1'b1;
                    end else if (!inflight) begin
                        state    <= Q_STOPPED;
                        qacceptn <= 1'b0;
                    end
`ifdef APB_ISO_TIMEOUT_EN
                    if (inflight) begin
                        to_cnt_q <= to_cnt_q + CW'(1);
                    end
`endif
                end
                Q_STOPPED: begin
                    if (qreqn) begin
                        state <= Q_EXIT;
                    end
                end
                Q_EXIT: begin
                    state    <= Q_RUN;
                    qacceptn <= 1'b1;
                end
                Q_DENIED: begin
                    if (qreqn) begin
                        state <= Q_CONTINUE;
                    end
                end
                Q_CONTINUE: begin
                    state <= Q_RUN;
                    qdeny <= 1'b0;
                end
                default: begin
                    state    <= Q_RUN;
                    qacceptn <= 1'b1;
                    qdeny    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/apb_isolator_qgate.sv
// apb_isolator_qgate: APB4 isolation gate controlled by an LPI Q-channel,
// placed in front of a power-gateable APB peripheral.
//   Parameters: AW, DW, ISO_RESP (0 stall / 1 local error while isolated),
//               DENY_ON_ACTIVE (deny when an upstream transfer is blocked),
//               TO_CYCLES (drain timeout, only with APB_ISO_TIMEOUT_EN).
//   pclk_i      clock
//   preset_i    synchronous reset, active-high
//   qreqn_i     quiescence request from the power controller (active-low)
//   qacceptn_o  Q-channel accept (active-low, registered)
//   qdeny_o     Q-channel deny (registered)
//   qactive_o   activity indication: upstream select or transfer in flight
//   s_apb       upstream APB port (this block is the slave)
//   m_apb       downstream APB port (this block is the master)
// Optional build macro: APB_ISO_TIMEOUT_EN enables the drain timeout.
module apb_isolator_qgate
    import apb_iso_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int ISO_RESP       = 0,
    parameter int DENY_ON_ACTIVE = 1,
    parameter int TO_CYCLES      = 64
) (
    input  logic                 pclk_i,
    input  logic                 preset_i,
    input  logic                 qreqn_i,
    output logic                 qacceptn_o,
    output logic                 qdeny_o,
    output logic                 qactive_o,
    apb_isolator_qgate_if.slave  s_apb,
    apb_isolator_qgate_if.master m_apb
);

    localparam int SW        = DW / 8;
    localparam bit LOCAL_ERR = (ISO_RESP != 0);

    if ((DW % 8) != 0) begin : g_dw_check
        $error("apb_isolator_qgate: DW must be a multiple of 8");
    end

    qstate_e q_state;
    logic    inflight_q;
    logic    blocked;
    logic    gate_open;
    logic    fwd;
    logic    local_cpl;
    logic    m_done;

    logic [AW-1:0]          m_paddr;
    logic [APB_PPROT_W-1:0] m_pprot;
    logic                   m_psel;
    logic                   m_penable;
    logic                   m_pwrite;
    logic [DW-1:0]          m_pwdata;
    logic [SW-1:0]          m_pstrb;
    logic                   s_pready;
    logic [DW-1:0]          s_prdata;
    logic                   s_pslverr;

    apb_iso_qfsm #(
        .DENY_ON_ACTIVE (DENY_ON_ACTIVE),
        .TO_CYCLES      (TO_CYCLES)
    ) u_qfsm (
        .pclk_i   (pclk_i),
        .preset_i (preset_i),
        .qreqn    (qreqn_i),
        .inflight (inflight_q),
        .blocked  (blocked),
        .state    (q_state),
        .qacceptn (qacceptn_o),
        .qdeny    (qdeny_o)
    );

    assign gate_open = gate_is_open(q_state, inflight_q);
    // Everything passes only while upstream selects, so an idle bus shows
    // all-zero request and response fields on both sides.
    assign fwd       = gate_open && s_apb.psel;
    assign blocked   = s_apb.psel && !inflight_q;
    assign m_done    = m_psel && m_penable && m_apb.pready;
    assign qactive_o = s_apb.psel || inflight_q;

    // In REQUEST the gate is closed for new work but no error is returned;
    // only a fully isolated peripheral answers locally.
    assign local_cpl = LOCAL_ERR && !gate_open && s_apb.psel && s_apb.penable &&
                       ((q_state == Q_STOPPED) || (q_state == Q_EXIT));

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            inflight_q <= 1'b0;
        end else if (m_done) begin
            inflight_q <= 1'b0;
        end else if (fwd && !s_apb.penable) begin
            inflight_q <= 1'b1;
        end
    end

    always_comb begin
        m_paddr   = '0;
        m_pprot   = '0;
        m_psel    = 1'b0;
        m_penable = 1'b0;
        m_pwrite  = 1'b0;
        m_pwdata  = '0;
        m_pstrb   = '0;
        s_pready  = 1'b0;
        s_prdata  = '0;
        s_pslverr = 1'b0;
        if (fwd) begin
            m_paddr   = s_apb.paddr;
            m_pprot   = s_apb.pprot;
            m_psel    = 1'b1;
            m_penable = s_apb.penable;
            m_pwrite  = s_apb.pwrite;
            m_pwdata  = s_apb.pwdata;
            m_pstrb   = s_apb.pstrb;
            s_pready  = m_apb.pready;
            s_prdata  = m_apb.prdata;
            s_pslverr = m_apb.pslverr;
        end else if (local_cpl) begin
            s_pready  = 1'b1;
            s_pslverr = 1'b1;
        end
    end

    assign m_apb.paddr   = m_paddr;
    assign m_apb.pprot   = m_pprot;
    assign m_apb.psel    = m_psel;
    assign m_apb.penable = m_penable;
    assign m_apb.pwrite  = m_pwrite;
    assign m_apb.pwdata  = m_pwdata;
    assign m_apb.pstrb   = m_pstrb;
    assign s_apb.pready  = s_pready;
    assign s_apb.prdata  = s_prdata;
    assign s_apb.pslverr = s_pslverr;

endmodule

// File: tb/tb_apb_isolator_qgate.sv
// Directed bench for apb_isolator_qgate. Two instances share all stimulus:
// dut0 stalls while isolated (ISO_RESP=0), dut1 answers locally (ISO_RESP=1).
// Both use DENY_ON_ACTIVE=1 and TO_CYCLES=8.
module tb_apb_isolator_qgate;
    import apb_iso_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic pclk_i = 1'b0;
    logic preset_i;
    logic qreqn;
    logic qacceptn0, qdeny0, qactive0;
    logic qacceptn1, qdeny1, qactive1;

    int n_checks = 0;
    int n_errors = 0;

    apb_isolator_qgate_if #(.AW(AW), .DW(DW)) s_if0 ();
    apb_isolator_qgate_if #(.AW(AW), .DW(DW)) m_if0 ();
    apb_isolator_qgate_if #(.AW(AW), .DW(DW)) s_if1 ();
    apb_isolator_qgate_if #(.AW(AW), .DW(DW)) m_if1 ();

    assign s_if1.paddr   = s_if0.paddr;
    assign s_if1.pprot   = s_if0.pprot;
    assign s_if1.psel    = s_if0.psel;
    assign s_if1.penable = s_if0.penable;
    assign s_if1.pwrite  = s_if0.pwrite;
    assign s_if1.pwdata  = s_if0.pwdata;
    assign s_if1.pstrb   = s_if0.pstrb;
    assign m_if1.pready  = m_if0.pready;
    assign m_if1.prdata  = m_if0.prdata;
    assign m_if1.pslverr = m_if0.pslverr;

    apb_isolator_qgate #(
        .AW(AW), .DW(DW), .ISO_RESP(0), .DENY_ON_ACTIVE(1), .TO_CYCLES(8)
    ) dut0 (
        .pclk_i     (pclk_i),
        .preset_i   (preset_i),
        .qreqn_i    (qreqn),
        .qacceptn_o (qacceptn0),
        .qdeny_o    (qdeny0),
        .qactive_o  (qactive0),
        .s_apb      (s_if0),
        .m_apb      (m_if0)
    );

    apb_isolator_qgate #(
        .AW(AW), .DW(DW), .ISO_RESP(1), .DENY_ON_ACTIVE(1), .TO_CYCLES(8)
    ) dut1 (
        .pclk_i     (pclk_i),
        .preset_i   (preset_i),
        .qreqn_i    (qreqn),
        .qacceptn_o (qacceptn1),
        .qdeny_o    (qdeny1),
        .qactive_o  (qactive1),
        .s_apb      (s_if1),
        .m_apb      (m_if1)
    );

    always #5 pclk_i = ~pclk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic up(input logic sel, input logic en, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        s_if0.psel    = sel;
        s_if0.penable = en;
        s_if0.pwrite  = wr;
        s_if0.paddr   = addr;
        s_if0.pwdata  = data;
        s_if0.pstrb   = strb;
        s_if0.pprot   = 3'b010;
    endtask

    task automatic dn(input logic rdy, input logic [31:0] rdata, input logic err);
        m_if0.pready  = rdy;
        m_if0.prdata  = rdata;
        m_if0.pslverr = err;
    endtask

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        preset_i = 1'b1;
        qreqn    = 1'b1;
        up(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        dn(1'b0, 32'h0, 1'b0);
        tick();
        tick();
        settle();
        check_val("rst_qacceptn", qacceptn0, 1);
        check_val("rst_qdeny", qdeny0, 0);
        check_val("rst_qactive", qactive0, 0);
        check_val("rst_m_psel", m_if0.psel, 0);
        check_val("rst_s_pready", s_if0.pready, 0);
        preset_i = 1'b0;

        // Plain write through an open gate
        tick();
        up(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'h5);
        settle();
        check_val("wr_setup_psel", m_if0.psel, 1);
        check_val("wr_setup_penable", m_if0.penable, 0);
        check_val("wr_paddr", m_if0.paddr, 32'h10);
        check_val("wr_pwdata", m_if0.pwdata, 32'hDEADBEEF);
        check_val("wr_pwrite", m_if0.pwrite, 1);
        check_val("wr_pstrb", m_if0.pstrb, 4'h5);
        check_val("wr_pprot", m_if0.pprot, 3'b010);
        check_val("wr_qactive", qactive0, 1);
        tick();
        up(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'h5);
        settle();
        check_val("wr_access_penable", m_if0.penable, 1);
        check_val("wr_wait_pready", s_if0.pready, 0);
        tick();
        dn(1'b1, 32'h0, 1'b0);
        settle();
        check_val("wr_done_pready", s_if0.pready, 1);
        check_val("wr_done_pslverr", s_if0.pslverr, 0);
        tick();
        up(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        dn(1'b0, 32'h0, 1'b0);
        settle();
        check_val("idle_qactive", qactive0, 0);
        check_val("idle_m_psel", m_if0.psel, 0);

        // qreqn falls with a read setup: the read drains before accept
        tick();
        qreqn = 1'b0;
        up(1'b1, 1'b0, 1'b0, 32'h24, 32'h0, 4'h0);
        settle();
        check_val("sim_fwd_psel", m_if0.psel, 1);
        tick();
        up(1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            settle();
            check_val("drain_qacceptn", qacceptn0, 1);
            check_val("drain_m_penable", m_if0.penable, 1);
            tick();
        end
        dn(1'b1, 32'hCAFEF00D, 1'b0);
        settle();
        check_val("drain_rd_pready", s_if0.pready, 1);
        check_val("drain_rd_prdata", s_if0.prdata, 32'hCAFEF00D);
        check_val("drain_done_qacceptn", qacceptn0, 1);
        tick();
        up(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        dn(1'b0, 32'h0, 1'b0);
        settle();
        check_val("accept_not_early", qacceptn0, 1);
        tick();
        settle();
        check_val("accept_qacceptn", qacceptn0, 0);
        check_val("accept_qdeny", qdeny0, 0);

        // Read while STOPPED: dut0 stalls, dut1 errors locally
        tick();
        up(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
        settle();
        check_val("iso_setup_m_psel", m_if0.psel, 0);
        check_val("iso_setup_qactive", qactive0, 1);
        check_val("iso_setup_pready1", s_if1.pready, 0);
        tick();
        up(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        dn(1'b1, 32'h5555AAAA, 1'b1);
        settle();
        check_val("iso_stall_pready0", s_if0.pready, 0);
        check_val("iso_stall_pslverr0", s_if0.pslverr, 0);
        check_val("iso_stall_prdata0", s_if0.prdata, 32'h0);
        check_val("iso_m_psel0", m_if0.psel, 0);
        check_val("iso_m_penable0", m_if0.penable, 0);
        check_val("iso_m_paddr0", m_if0.paddr, 32'h0);
        check_val("iso_local_pready1", s_if1.pready, 1);
        check_val("iso_local_pslverr1", s_if1.pslverr, 1);
        check_val("iso_local_prdata1", s_if1.prdata, 32'h0);
        check_val("iso_m_psel1", m_if1.psel, 0);
        tick();
        qreqn = 1'b1;
        settle();
        check_val("iso_hold_pready0", s_if0.pready, 0);
        tick();
        settle();
        check_val("exit_qacceptn", qacceptn0, 0);
        check_val("exit_m_psel0", m_if0.psel, 0);
        check_val("exit_local_pready1", s_if1.pready, 1);
        tick();
        dn(1'b1, 32'h12345678, 1'b1);
        settle();
        check_val("run_qacceptn", qacceptn0, 1);
        check_val("run_fwd_psel", m_if0.psel, 1);
        check_val("run_fwd_penable", m_if0.penable, 1);
        check_val("run_fwd_paddr", m_if0.paddr, 32'h20);
        check_val("run_fwd_pready", s_if0.pready, 1);
        check_val("run_fwd_prdata", s_if0.prdata, 32'h12345678);
        check_val("run_fwd_pslverr", s_if0.pslverr, 1);
        tick();
        up(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        dn(1'b0, 32'h0, 1'b0);

        // Idle quiescence, then a write while STOPPED
        tick();
        qreqn = 1'b0;
        settle();
        tick();
        settle();
        tick();
        settle();
        check_val("idle_accept", qacceptn1, 0);
        tick();
        up(1'b1, 1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF);
        settle();
        check_val("isow_setup_pready1", s_if1.pready, 0);
        tick();
        up(1'b1, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF);
        settle();
        check_val("isow_pready1", s_if1.pready, 1);
        check_val("isow_pslverr1", s_if1.pslverr, 1);
        check_val("isow_m_psel1", m_if1.psel, 0);
        check_val("isow_m_penable1", m_if1.penable, 0);
        check_val("isow_m_pwdata1", m_if1.pwdata, 32'h0);
        check_val("isow_pready0", s_if0.pready, 0);
        tick();
        up(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        qreqn = 1'b1;
        tick();
        tick();
        settle();
        check_val("isow_back_run", qacceptn1, 1);

        // Deny: upstream transfer blocked while REQUEST with nothing in flight
        tick();
        qreqn = 1'b0;
        settle();
        tick();
        up(1'b1, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, 4'h3);
        settle();
        check_val("blk_m_psel", m_if0.psel, 0);
        check_val("blk_qactive", qactive0, 1);
        check_val("blk_qdeny", qdeny0, 0);
        check_val("blk_qacceptn", qacceptn0, 1);
        tick();
        up(1'b1, 1'b1, 1'b1, 32'h40, 32'h0BADF00D, 4'h3);
        dn(1'b1, 32'h0, 1'b0);
        settle();
        check_val("deny_qdeny", qdeny0, 1);
        check_val("deny_qacceptn", qacceptn0, 1);
        check_val("deny_fwd_psel", m_if0.psel, 1);
        check_val("deny_fwd_penable", m_if0.penable, 1);
        check_val("deny_fwd_pwdata", m_if0.pwdata, 32'h0BADF00D);
        check_val("deny_fwd_pready", s_if0.pready, 1);
        tick();
        up(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        dn(1'b0, 32'h0, 1'b0);
        qreqn = 1'b1;
        settle();
        check_val("denied_hold_qdeny", qdeny0, 1);
        tick();
        settle();
        check_val("continue_qdeny", qdeny0, 1);
        tick();
        settle();
        check_val("deny_release", qdeny0, 0);

        // Stuck downstream transfer, then reset in the middle of it
        tick();
        qreqn = 1'b0;
        up(1'b1, 1'b0, 1'b1, 32'h50, 32'h11112222, 4'hF);
        settle();
        tick();
        up(1'b1, 1'b1, 1'b1, 32'h50, 32'h11112222, 4'hF);
        settle();
        check_val("stuck_qactive", qactive0, 1);
`ifdef APB_ISO_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            settle();
            check_val("to_wait_qdeny", qdeny0, 0);
        end
        tick();
        settle();
        check_val("to_qdeny", qdeny0, 1);
        check_val("to_gate_open", m_if0.psel, 1);
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            settle();
            check_val("stuck_qacceptn", qacceptn0, 1);
            check_val("stuck_qdeny", qdeny0, 0);
        end
`endif
        tick();
        preset_i = 1'b1;
        qreqn    = 1'b1;
        up(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        settle();
        check_val("mid_rst_qacceptn", qacceptn0, 1);
        check_val("mid_rst_qdeny", qdeny0, 0);
        check_val("mid_rst_qactive", qactive0, 0);
        check_val("mid_rst_m_psel", m_if0.psel, 0);
        check_val("mid_rst_m_pwdata", m_if0.pwdata, 32'h0);
        check_val("mid_rst_s_pready", s_if0.pready, 0);
        preset_i = 1'b0;
        tick();
        qreqn = 1'b0;
        settle();
        tick();
        settle();
        tick();
        settle();
        check_val("post_rst_accept", qacceptn0, 0);
        qreqn = 1'b1;
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
